// File: rtl/cache_pkg.sv
// Shared types and widths for the single-line cache sequencer.
// Line state codes, FSM states and field widths.
package cache_pkg;

   localparam int ADDR_W  = 3;
   localparam int DATA_W  = 4;
   localparam int OWNER_W = 2;

   localparam logic [1:0] INVALID  = 2'b00;
   localparam logic [1:0] SHARED   = 2'b01;
   localparam logic [1:0] MODIFIED = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WRITEBACK,
      FILL,
      UPDATE,
      RESP
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request after the last winner.
// Purely combinational, one-hot result plus its index.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic [N-1:0] req,
   input  logic [1:0]   last,
   output logic [N-1:0] pick,
   output logic [1:0]   pick_idx
);

   // scan backwards so the slot nearest last+1 is assigned last and wins
   always_comb begin
      pick     = '0;
      pick_idx = '0;
      for (int k = N; k >= 1; k--) begin
         if (req[(int'(last) + k) % N]) begin
            pick = '0;
            pick[(int'(last) + k) % N] = 1'b1;
            pick_idx = 2'((int'(last) + k) % N);
         end
      end
   end

endmodule

// File: rtl/cache_line_controller.sv
// Transaction sequencer for the shared single-line cache_D.
// Arbitrates requesters, handles writeback, fill and update.
module cache_line_controller
   import cache_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
   input  logic [DATA_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        done,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      line_write,
   output logic [1:0]                line_state,
   output logic [OWNER_W-1:0]        line_owner,
   output logic [ADDR_W-1:0]         line_address,
   output logic [DATA_W-1:0]         line_data,
   input  logic [1:0]                cur_state,
   input  logic [OWNER_W-1:0]        cur_owner,
   input  logic [ADDR_W-1:0]         cur_address,
   input  logic [DATA_W-1:0]         cur_data,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   state_t               state;
   state_t               next;
   logic [NUM_REQ-1:0]   pick;
   logic [NUM_REQ-1:0]   sel_q;
   logic [1:0]           last;
   logic [1:0]           pick_idx;
   logic [OWNER_W-1:0]   id_q;
   logic                 wr_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    data_q;
   logic                 hit;
   logic                 dirty;
   logic                 unused_owner;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req      (req),
      .last     (last),
      .pick     (pick),
      .pick_idx (pick_idx)
   );

   assign hit   = (cur_state != INVALID) && (cur_address == addr_q);
   assign dirty = (cur_state == MODIFIED);
   assign unused_owner = ^cur_owner;

   // state register, arbitration pointer and latched request
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         last   <= 2'(NUM_REQ - 1);
         sel_q  <= '0;
         id_q   <= '0;
         wr_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         state <= next;
         if (state == IDLE && |req) begin
            last   <= pick_idx;
            sel_q  <= pick;
            id_q   <= pick_idx + 2'd1;
            wr_q   <= req_write[pick_idx];
            addr_q <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            data_q <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
         end
      end
   end

   // next-state and Moore output decode
   always_comb begin
      next         = state;
      grant        = '0;
      done         = '0;
      rsp_data     = '0;
      line_write   = 1'b0;
      line_state   = INVALID;
      line_owner   = '0;
      line_address = '0;
      line_data    = '0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      unique case (state)
         IDLE: begin
            if (|req) next = LOOKUP;
         end
         LOOKUP: begin
            grant = sel_q;
            if (!wr_q)
               next = hit ? RESP : (dirty ? WRITEBACK : FILL);
            else
               next = (!hit && dirty) ? WRITEBACK : UPDATE;
         end
         WRITEBACK: begin
            grant     = sel_q;
            mem_we    = 1'b1;
            mem_addr  = cur_address;
            mem_wdata = cur_data;
            next      = wr_q ? UPDATE : FILL;
         end
         FILL: begin
            grant        = sel_q;
            mem_addr     = addr_q;
            line_write   = 1'b1;
            line_state   = SHARED;
            line_owner   = id_q;
            line_address = addr_q;
            line_data    = mem_rdata;
            next         = RESP;
         end
         UPDATE: begin
            grant        = sel_q;
            line_write   = 1'b1;
            line_state   = MODIFIED;
            line_owner   = id_q;
            line_address = addr_q;
            line_data    = data_q;
            next         = RESP;
         end
         RESP: begin
            grant    = sel_q;
            done     = sel_q;
            rsp_data = cur_data;
            next     = IDLE;
         end
         default: next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_line_controller.sv
// Self-checking bench for cache_line_controller.
// Holds a cache_D/memory environment and a transaction-level model.
module tb_cache_line_controller;

   localparam int N = 3;

   logic           clock = 1'b0;
   logic           resetn;
   logic [N-1:0]   req;
   logic [N-1:0]   req_write;
   logic [3*N-1:0] req_addr;
   logic [4*N-1:0] req_data;
   logic [N-1:0]   grant;
   logic [N-1:0]   done;
   logic [3:0]     rsp_data;
   logic           line_write;
   logic [1:0]     line_state;
   logic [1:0]     line_owner;
   logic [2:0]     line_address;
   logic [3:0]     line_data;
   logic [1:0]     cur_state;
   logic [1:0]     cur_owner;
   logic [2:0]     cur_address;
   logic [3:0]     cur_data;
   logic           mem_we;
   logic [2:0]     mem_addr;
   logic [3:0]     mem_wdata;
   logic [3:0]     mem_rdata;
   logic           env_init;
   logic [3:0]     mem [8];

   int n_checks = 0;
   int n_fail = 0;

   logic [1:0] m_st;
   logic [1:0] m_own;
   logic [2:0] m_addr;
   logic [3:0] m_data;
   logic [3:0] m_mem [8];

   always #5 clock = ~clock;

   cache_line_controller #(.NUM_REQ(N)) dut (
      .clock        (clock),
      .resetn       (resetn),
      .req          (req),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .grant        (grant),
      .done         (done),
      .rsp_data     (rsp_data),
      .line_write   (line_write),
      .line_state   (line_state),
      .line_owner   (line_owner),
      .line_address (line_address),
      .line_data    (line_data),
      .cur_state    (cur_state),
      .cur_owner    (cur_owner),
      .cur_address  (cur_address),
      .cur_data     (cur_data),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   // cache_D line register and backing memory
   always @(posedge clock) begin
      if (env_init) begin
         cur_state   <= 2'b00;
         cur_owner   <= 2'b00;
         cur_address <= 3'd0;
         cur_data    <= 4'd0;
         for (int k = 0; k < 8; k++) mem[k] <= 4'(k) ^ 4'hC;
      end else begin
         if (line_write) begin
            cur_state   <= line_state;
            cur_owner   <= line_owner;
            cur_address <= line_address;
            cur_data    <= line_data;
         end
         if (mem_we) mem[mem_addr] <= mem_wdata;
      end
   end

   assign mem_rdata = mem[mem_addr];

   task automatic model_init();
      m_st = 2'b00;
      m_own = 2'b00;
      m_addr = 3'd0;
      m_data = 4'd0;
      for (int k = 0; k < 8; k++) m_mem[k] = 4'(k) ^ 4'hC;
   endtask

   task automatic env_reinit();
      @(negedge clock);
      env_init = 1'b1;
      @(negedge clock);
      env_init = 1'b0;
      model_init();
   endtask

   task automatic do_txn(input int i, input bit wr, input logic [2:0] a,
                         input logic [3:0] d, input string nm);
      bit hit;
      bit dirty;
      int exp_lat;
      int exp_lw;
      int exp_mw;
      int lat;
      int lw;
      int mw;
      logic [3:0] rsp;
      logic [1:0] e_st;
      logic [1:0] e_own;
      logic [2:0] e_addr;
      logic [3:0] e_data;
      logic [2:0] wb_addr;
      logic [3:0] wb_data;
      logic [2:0] exp_g;
      hit = (m_st != 2'b00) && (m_addr == a);
      dirty = !hit && (m_st == 2'b10);
      wb_addr = m_addr;
      wb_data = m_data;
      exp_g = 3'b001 << i;
      exp_mw = dirty ? 1 : 0;
      if (wr) begin
         exp_lat = dirty ? 4 : 3;
         exp_lw = 1;
         e_st = 2'b10;
         e_own = 2'(i + 1);
         e_addr = a;
         e_data = d;
      end else if (hit) begin
         exp_lat = 2;
         exp_lw = 0;
         e_st = m_st;
         e_own = m_own;
         e_addr = m_addr;
         e_data = m_data;
      end else begin
         exp_lat = dirty ? 4 : 3;
         exp_lw = 1;
         e_st = 2'b01;
         e_own = 2'(i + 1);
         e_addr = a;
         e_data = m_mem[a];
      end
      @(negedge clock);
      req = '0;
      req[i] = 1'b1;
      req_write[i] = wr;
      req_addr[3*i +: 3] = a;
      req_data[4*i +: 4] = d;
      @(negedge clock);
      req = '0;
      lat = -1;
      lw = 0;
      mw = 0;
      rsp = 4'd0;
      for (int c = 1; c <= 8 && lat < 0; c++) begin
         if (c > 1) @(negedge clock);
         n_checks++;
         if (grant !== exp_g) begin
            n_fail++;
            $display("FAIL %s grant c%0d: got %b want %b", nm, c, grant, exp_g);
         end
         if (line_write === 1'b1) begin
            lw++;
            n_checks++;
            if ({line_state, line_owner, line_address, line_data}
                !== {e_st, e_own, e_addr, e_data}) begin
               n_fail++;
               $display("FAIL %s line fields: got %b/%0d/%0d/%h want %b/%0d/%0d/%h",
                        nm, line_state, line_owner, line_address, line_data,
                        e_st, e_own, e_addr, e_data);
            end
         end
         if (mem_we === 1'b1) begin
            mw++;
            n_checks++;
            if ({mem_addr, mem_wdata} !== {wb_addr, wb_data}) begin
               n_fail++;
               $display("FAIL %s writeback: got @%0d=%h want @%0d=%h",
                        nm, mem_addr, mem_wdata, wb_addr, wb_data);
            end
         end
         if (done !== 3'b000) begin
            lat = c;
            rsp = rsp_data;
            n_checks++;
            if (done !== exp_g) begin
               n_fail++;
               $display("FAIL %s done: got %b want %b", nm, done, exp_g);
            end
         end
      end
      n_checks++;
      if (lat != exp_lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
      end
      n_checks++;
      if (rsp !== e_data) begin
         n_fail++;
         $display("FAIL %s rsp_data: got %h want %h", nm, rsp, e_data);
      end
      n_checks++;
      if (lw != exp_lw || mw != exp_mw) begin
         n_fail++;
         $display("FAIL %s pulses: got lw=%0d mw=%0d want lw=%0d mw=%0d",
                  nm, lw, mw, exp_lw, exp_mw);
      end
      if (dirty) m_mem[wb_addr] = wb_data;
      m_st = e_st;
      m_own = e_own;
      m_addr = e_addr;
      m_data = e_data;
      n_checks++;
      if ({cur_state, cur_owner, cur_address, cur_data}
          !== {m_st, m_own, m_addr, m_data}) begin
         n_fail++;
         $display("FAIL %s line after: got %b/%0d/%0d/%h want %b/%0d/%0d/%h",
                  nm, cur_state, cur_owner, cur_address, cur_data,
                  m_st, m_own, m_addr, m_data);
      end
      if (dirty) begin
         n_checks++;
         if (mem[wb_addr] !== wb_data) begin
            n_fail++;
            $display("FAIL %s memory after: got %h want %h",
                     nm, mem[wb_addr], wb_data);
         end
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if (grant !== 3'b000 || done !== 3'b000) begin
         n_fail++;
         $display("FAIL reset grant/done: got %b/%b want 000/000", grant, done);
      end
      n_checks++;
      if (line_write !== 1'b0 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL reset strobes: got lw=%b we=%b want 0/0", line_write, mem_we);
      end
      n_checks++;
      if ({line_state, line_owner, line_address, line_data} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset line fields: got %h want 0",
                  {line_state, line_owner, line_address, line_data});
      end
      n_checks++;
      if ({mem_addr, mem_wdata, rsp_data} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset mem/rsp: got %h want 0", {mem_addr, mem_wdata, rsp_data});
      end
   endtask

   task automatic test_directed();
      do_txn(0, 1'b0, 3'd5, 4'h0, "read_fill");
      do_txn(1, 1'b0, 3'd5, 4'h0, "read_hit");
      do_txn(2, 1'b1, 3'd5, 4'hC, "write_hit");
      do_txn(0, 1'b0, 3'd2, 4'h0, "read_dirty_miss");
      do_txn(1, 1'b1, 3'd2, 4'h3, "write_take_owner");
      do_txn(2, 1'b1, 3'd6, 4'h7, "write_dirty_miss");
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_g [4];
      logic [2:0] prev;
      int p;
      int got;
      int gap;
      bit found;
      bit quiet;
      p = N - 1;
      for (int t = 0; t < 4; t++) begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            if (!found) begin
               exp_g[t] = 3'b001 << ((p + k) % N);
               p = (p + k) % N;
               found = 1'b1;
            end
         end
      end
      @(negedge clock);
      resetn = 1'b0;
      req = '1;
      req_write = '0;
      req_addr = {3'd1, 3'd1, 3'd1};
      @(negedge clock);
      resetn = 1'b1;
      got = 0;
      gap = 0;
      prev = 3'b000;
      for (int c = 0; c < 60 && got < 4; c++) begin
         @(negedge clock);
         n_checks++;
         if (!$onehot0(grant)) begin
            n_fail++;
            $display("FAIL rr onehot: got %b want at most one bit", grant);
         end
         if (grant !== 3'b000 && prev === 3'b000) begin
            n_checks++;
            if (grant !== exp_g[got]) begin
               n_fail++;
               $display("FAIL rr grant %0d: got %b want %b", got, grant, exp_g[got]);
            end
            if (got > 0) begin
               n_checks++;
               if (gap != 1) begin
                  n_fail++;
                  $display("FAIL rr idle gap %0d: got %0d want 1", got, gap);
               end
            end
            got++;
            if (got == 4) req = '0;
         end
         gap = (grant === 3'b000) ? gap + 1 : 0;
         prev = grant;
      end
      n_checks++;
      if (got != 4) begin
         n_fail++;
         $display("FAIL rr timeout: got %0d grants want 4", got);
      end
      quiet = 1'b0;
      for (int c = 0; c < 10 && !quiet; c++) begin
         @(negedge clock);
         if (grant === 3'b000) quiet = 1'b1;
      end
      n_checks++;
      if (!quiet) begin
         n_fail++;
         $display("FAIL rr drain: got grant %b want 000", grant);
      end
      env_reinit();
   endtask

   task automatic test_reset_writeback();
      bit seen;
      bit bad;
      do_txn(1, 1'b1, 3'd5, 4'hC, "wb_setup");
      @(negedge clock);
      req = 3'b001;
      req_write = '0;
      req_addr[2:0] = 3'd2;
      @(negedge clock);
      req = '0;
      seen = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
         if (mem_we === 1'b1) seen = 1'b1;
         else @(negedge clock);
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL rst_wb no writeback: got mem_we=%b want 1", mem_we);
      end
      resetn = 1'b0;
      #1;
      n_checks++;
      if (mem_we !== 1'b0 || grant !== 3'b000 || line_write !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_wb async drop: got we=%b grant=%b lw=%b want 0/000/0",
                  mem_we, grant, line_write);
      end
      @(negedge clock);
      resetn = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         if (line_write !== 1'b0 || grant !== 3'b000) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin
         n_fail++;
         $display("FAIL rst_wb idle after: got activity=%b want 0", bad);
      end
      n_checks++;
      if (mem[5] !== m_mem[5]) begin
         n_fail++;
         $display("FAIL rst_wb memory: got %h want %h", mem[5], m_mem[5]);
      end
      do_txn(0, 1'b0, 3'd5, 4'h0, "post_reset_hit");
   endtask

   task automatic test_random();
      int i;
      bit wr;
      logic [2:0] a;
      logic [3:0] d;
      for (int t = 0; t < 40; t++) begin
         i = $urandom_range(0, N - 1);
         wr = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 1) == 1) ? m_addr : 3'($urandom_range(0, 7));
         d = 4'($urandom);
         do_txn(i, wr, a, d, "random");
      end
   endtask

   initial begin
      resetn = 1'b0;
      env_init = 1'b1;
      req = '0;
      req_write = '0;
      req_addr = '0;
      req_data = '0;
      model_init();
      repeat (2) @(negedge clock);
      test_reset();
      env_init = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      test_directed();
      test_back_to_back();
      test_reset_writeback();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_line_controller.md
# cache_line_controller

Sequencing controller for the shared single-line `cache_D` data cache. It arbitrates between up to three processor requesters with a round-robin policy and runs one read or write transaction at a time. For each transaction it looks up the line, writes a dirty victim back to memory, fills from memory or merges write data, and drives the `cache_D` write port. It sits between the processor request ports, one `cache_D` instance and the backing memory.

## Interface
- `NUM_REQ`, default 3: number of requesters, legal range 1–3. Requester i has owner ID i+1; owner 0 means none.
- `clock` in 1: single clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `req` in NUM_REQ: per-requester request level.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in 3·NUM_REQ: per-requester address; slice i is bits [3i+2:3i].
- `req_data` in 4·NUM_REQ: per-requester write data; slice i is bits [4i+3:4i].
- `grant` out NUM_REQ: one-hot, identifies the requester being served.
- `done` out NUM_REQ: one-cycle completion pulse to the served requester.
- `rsp_data` out 4: line data, valid while `done` is high.
- `line_write` out 1: drives the write strobe of `cache_D`.
- `line_state` out 2, `line_owner` out 2, `line_address` out 3, `line_data` out 4: the `cache_D` write fields.
- `cur_state` in 2, `cur_owner` in 2, `cur_address` in 3, `cur_data` in 4: the `cache_D` current outputs.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 3: memory address.
- `mem_wdata` out 4: memory write data.
- `mem_rdata` in 4: memory read data, valid combinationally in the same cycle as `mem_addr`.

## Operation
- Line state encoding:
  - 00 Invalid.
  - 01 Shared (clean).
  - 10 Modified (dirty).
  - 11 is reserved and is treated as valid and clean.
- Hit = (`cur_state` != 00) and (`cur_address` == latched address).
- FSM states are IDLE, LOOKUP, WRITEBACK, FILL, UPDATE and RESP.
- IDLE:
  - If any `req` bit is set, the round-robin arbiter picks the first set bit starting at `last+1`, wrapping around.
  - The chosen requester's ID, write flag, address and data are latched.
  - `last` is updated to the chosen index and the FSM goes to LOOKUP.
  - Requester inputs are don't-care after the latch.
- LOOKUP is a single cycle with no outputs other than `grant`. Next state:
  - Read hit: RESP.
  - Read miss with `cur_state`=10: WRITEBACK.
  - Read miss otherwise: FILL.
  - Write miss with `cur_state`=10: WRITEBACK.
  - Write in all other cases: UPDATE.
- WRITEBACK:
  - Drives `mem_we`=1, `mem_addr`=`cur_address`, `mem_wdata`=`cur_data`.
  - Goes to FILL for a read, UPDATE for a write.
- FILL:
  - Drives `mem_addr` = latched address.
  - Drives `line_write`=1 with state=01, owner=ID, address=latched address, data=`mem_rdata`.
  - Goes to RESP.
- UPDATE:
  - Drives `line_write`=1 with state=10, owner=ID, address=latched address, data=latched data.
  - Goes to RESP.
  - A write hit on a line owned by another requester simply takes ownership.
- RESP:
  - `done`[ID-1]=1 and `rsp_data`=`cur_data`, which already reflects any update.
  - Goes to IDLE.
- `grant` is high from LOOKUP through RESP inclusive.
- A `req` still high in the cycle after RESP is treated as a new request. The pointer has already advanced, so other pending requesters win first.
- All outputs are a Moore decode of the state register and the latched request. Outputs not driven in a state are 0.

## Timing
- Reset (`resetn`=0, asynchronous):
  - State goes to IDLE and `last` goes to NUM_REQ−1, so requester 0 has first priority.
  - All outputs go to 0 immediately, including `line_write`. This holds mid-transaction as well.
  - `cache_D` contents are not touched.
- Latency counts from the IDLE cycle in which `req` is sampled (cycle 0). `done` is asserted in:
  - Read hit: cycle 2.
  - Clean read miss: cycle 3.
  - Dirty read miss: cycle 4.
  - Write (hit, or miss on a clean line): cycle 3.
  - Dirty write miss: cycle 4.
- `line_write` is high for exactly one cycle per fill or update. `cache_D` captures the fields at that cycle's rising edge.
- The FSM is back-to-back capable: IDLE lasts one cycle between transactions when requests are pending.
- Simultaneous requests: exactly one grant is issued; the rest wait in order.

## Structure
- `cache_pkg` holds:
  - Line state constants (INVALID, SHARED, MODIFIED).
  - The FSM state enumeration.
  - Field widths (ADDR_W=3, DATA_W=4, OWNER_W=2).
- The round-robin picker is a natural separate sub-module, `rr_arbiter`: combinational pick from `req` plus `last`, giving a one-hot result.
- The controller instantiates `rr_arbiter` once. `cache_D` and memory stay outside the block.

## Test plan
- Reset, then read by requester 0 at address 5 with the line Invalid and `mem_rdata`=0x9:
  - FILL writes state 01, owner 1, address 5, data 0x9.
  - `done`[0] in cycle 3 with `rsp_data`=0x9.
- Read by requester 1 at address 5 after that fill:
  - Hit; `done`[1] in cycle 2, `rsp_data`=0x9, no `line_write`.
- Write 0xC at address 5 by requester 2:
  - UPDATE writes state 10, owner 3, data 0xC.
- Read at address 2 by requester 0 with the line Modified at address 5, data 0xC:
  - WRITEBACK with `mem_we`=1, `mem_addr`=5, `mem_wdata`=0xC, then FILL at address 2.
  - `done` in cycle 4.
- `req`=111 held continuously from reset:
  - Grants cycle 001, 010, 100, 001 across consecutive transactions.
- `resetn` asserted during WRITEBACK:
  - `mem_we` and `grant` drop without waiting for a clock edge, and the FSM is in IDLE after release.
  - With no request pending, no `line_write` occurs.
